// File: rtl/up_down_count_sequencer.sv
// up_down_count_sequencer
// Sequences an external mod-2^WIDTH up/down counter through one of three jobs:
// count up to a target, count down to a target, or bounce between 0 and a
// target for a programmed number of passes.
// Optional feature macro: COUNT_WDOG_EN adds a stall watchdog with a sticky ERR state.

module up_down_count_sequencer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_target,
    input  logic [3:0]       i_passes,
    input  logic             i_pause,
    input  logic [WIDTH-1:0] i_count_in,
    output logic             o_cnt_clr,
    output logic             o_cnt_en,
    output logic             o_cnt_up,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_pass_cnt,
    output logic             o_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_RUN_UP = 3'd2;
    localparam logic [2:0] S_RUN_DN = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
`ifdef COUNT_WDOG_EN
    localparam logic [2:0] S_ERR    = 3'd5;
    localparam int         TIMER_W  = $clog2(TIMEOUT + 1);
`endif

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_target;
    logic [3:0]       r_passes;
    logic [3:0]       r_pass_cnt;
    logic [3:0]       w_pass_next;
    logic [WIDTH-1:0] w_end_value;
    logic             w_running;
    logic             w_at_end;
    logic             w_cnt_en;
    logic             w_accept;

    // The down-leg of a bounce always heads for 0; every other leg heads for the latched target.
    assign w_end_value = (r_state == S_RUN_DN && r_mode == MODE_BOUNCE) ? '0 : r_target;
    assign w_at_end    = (i_count_in == w_end_value);
    assign w_running   = (r_state == S_RUN_UP) || (r_state == S_RUN_DN);
    assign w_pass_next = r_pass_cnt + 4'd1;
    assign w_accept    = (r_state == S_IDLE) && i_start && (i_mode != MODE_RSVD);

    // Enable is Mealy so the counter stops on the very cycle it shows the end value;
    // gating with i_clear makes it drop as soon as reset is asserted.
    assign w_cnt_en = i_clear && w_running && !i_pause && !w_at_end;

`ifdef COUNT_WDOG_EN
    logic [TIMER_W-1:0] r_timer;
    logic [WIDTH-1:0]   r_prev_count;
    logic               w_stall;
    logic               w_timeout;

    assign w_stall   = w_cnt_en && (i_count_in == r_prev_count);
    assign w_timeout = w_stall && (r_timer == TIMER_W'(TIMEOUT - 1));
`endif

    // Next-state selection: leg transitions happen when the counter shows the end value, regardless of pause.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_CLR;
                end
            end
            S_CLR: begin
                w_next_state = (r_mode == MODE_DOWN) ? S_RUN_DN : S_RUN_UP;
            end
            S_RUN_UP: begin
                if (w_at_end) begin
                    w_next_state = (r_mode == MODE_BOUNCE) ? S_RUN_DN : S_FINISH;
                end
            end
            S_RUN_DN: begin
                if (w_at_end) begin
                    if (r_mode == MODE_BOUNCE) begin
                        w_next_state = (w_pass_next == r_passes) ? S_FINISH : S_RUN_UP;
                    end else begin
                        w_next_state = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
`ifdef COUNT_WDOG_EN
            S_ERR: begin
                w_next_state = S_ERR;
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
`ifdef COUNT_WDOG_EN
        if (w_running && w_timeout) begin
            w_next_state = S_ERR;
        end
`endif
    end

    // State register, job latch on an accepted start, and bounce pass counting.
    always_ff @(posedge i_clk) begin
        if (!i_clear) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'b00;
            r_target   <= '0;
            r_passes   <= 4'd0;
            r_pass_cnt <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_mode     <= i_mode;
                r_target   <= i_target;
                r_passes   <= (i_passes == 4'd0) ? 4'd1 : i_passes;
                r_pass_cnt <= 4'd0;
            end else if (r_state == S_RUN_DN && r_mode == MODE_BOUNCE && w_at_end) begin
                r_pass_cnt <= w_pass_next;
            end
        end
    end

`ifdef COUNT_WDOG_EN
    // Stall timer: counts consecutive enabled cycles with no counter movement, restarting on every leg entry.
    always_ff @(posedge i_clk) begin
        if (!i_clear) begin
            r_timer      <= '0;
            r_prev_count <= '0;
        end else begin
            r_prev_count <= i_count_in;
            if (w_running && (w_next_state == r_state) && w_stall) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign o_error = (r_state == S_ERR);
`else
    // Without the watchdog the error flag folds to a constant 0.
    assign o_error = (TIMEOUT < 0);
`endif

    assign o_cnt_clr  = (r_state == S_CLR);
    assign o_cnt_en   = w_cnt_en;
    assign o_cnt_up   = (r_state == S_RUN_UP);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_FINISH);
    assign o_pass_cnt = r_pass_cnt;

endmodule

// File: tb/tb_up_down_count_sequencer.sv
// Testbench for up_down_count_sequencer: behavioural counter plus a job-level
// reference model (expected count sequence, DONE cycle and pass counts).

module tb_up_down_count_sequencer;

    localparam int W    = 4;
    localparam int MODN = 16;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic [1:0] mode;
    logic [3:0] target;
    logic [3:0] passes;
    logic       pause;
    logic [3:0] count = 4'd0;
    logic       cntClr;
    logic       cntEn;
    logic       cntUp;
    logic       busy;
    logic       done;
    logic [3:0] passCnt;
    logic       error;
    bit         freezeCounter = 1'b0;

    int checks   = 0;
    int failures = 0;

    up_down_count_sequencer #(
        .WIDTH   (W),
        .TIMEOUT (8)
    ) dut (
        .i_clk      (clk),
        .i_clear    (clear),
        .i_start    (start),
        .i_mode     (mode),
        .i_target   (target),
        .i_passes   (passes),
        .i_pause    (pause),
        .i_count_in (count),
        .o_cnt_clr  (cntClr),
        .o_cnt_en   (cntEn),
        .o_cnt_up   (cntUp),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass_cnt (passCnt),
        .o_error    (error)
    );

    always #5 clk = ~clk;

    // Behavioural external counter driven by the DUT's controls.
    always @(posedge clk) begin
        if (freezeCounter)   count <= 4'd1;
        else if (cntClr)     count <= 4'd0;
        else if (cntEn)      count <= cntUp ? count + 4'd1 : count - 4'd1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] m, input logic [3:0] t, input logic [3:0] p);
        start  = s;
        mode   = m;
        target = t;
        passes = p;
    endtask

    // Runs one job and compares it against sequences computed from the job rules.
    task automatic runJob(input int jm, input int jt, input int jp,
                          input int pauseAt, input int pauseLen, input int midStartAt);
        int expSeq[$];
        int obsSeq[$];
        int effP, steps, expDone, expPass, k, doneCycle, doneCount, pauseRemain, firstBad;
        bit pauseUsed, timedOut, running;
        effP  = (jp == 0) ? 1 : jp;
        steps = (MODN - jt) % MODN;
        if (jm == 0) begin
            for (int v = 0; v <= jt; v++) expSeq.push_back(v);
            expDone = 2 + jt;
        end else if (jm == 1) begin
            for (int s = 0; s <= steps; s++) expSeq.push_back((MODN - s) % MODN);
            expDone = 2 + steps;
        end else begin
            for (int p = 0; p < effP; p++) begin
                for (int v = 0; v <= jt; v++) expSeq.push_back(v);
                for (int v = jt; v >= 0; v--) expSeq.push_back(v);
            end
            expDone = 1 + effP * (2 * jt + 2);
        end
        if (pauseAt >= 0) expDone += pauseLen;
        expPass = (jm == 2) ? effP : 0;

        pause = 1'b0;
        applyStimulus(1'b1, 2'(jm), 4'(jt), 4'(jp));
        stepCycle();
        start  = 1'b0;
        mode   = 2'($urandom_range(0, 3));
        target = 4'($urandom_range(0, 15));
        passes = 4'($urandom_range(0, 15));
        checkOutput("start_cnt_clr", cntClr, 1);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_pass_clear", passCnt, 0);

        k = 0; doneCycle = -1; doneCount = 0; pauseRemain = 0; pauseUsed = 0; timedOut = 0;
        while (1) begin
            running = busy && !cntClr && !done;
            if (done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = k;
                checkOutput("done_pass_cnt", passCnt, expPass);
            end
            if (pauseRemain > 0) begin
                pause = 1'b1;
                pauseRemain--;
            end else if (!pauseUsed && pauseAt >= 0 && running && count == pauseAt) begin
                pause = 1'b1;
                pauseUsed = 1'b1;
                pauseRemain = pauseLen - 1;
            end else begin
                pause = 1'b0;
            end
            start = (k == midStartAt) && busy;
            if (start) begin
                mode   = 2'($urandom_range(0, 2));
                target = 4'($urandom_range(0, 15));
            end
            #1;
            checkOutput("clr_en_exclusive", cntClr && cntEn, 0);
            checkOutput("error_low", error, 0);
            if (pause) begin
                checkOutput("pause_en_low", cntEn, 0);
                checkOutput("pause_count_hold", count, pauseAt);
            end
            if (running && !pause) begin
                obsSeq.push_back(count);
                if (jm != 2) checkOutput("direction", cntUp, (jm == 0) ? 1 : 0);
                checkOutput("pass_progress", passCnt,
                            (jm == 2) ? (obsSeq.size() - 1) / (2 * jt + 2) : 0);
            end
            if (!busy && k > 0) break;
            if (k >= 300) begin
                timedOut = 1'b1;
                break;
            end
            stepCycle();
            k++;
        end
        start = 1'b0;
        pause = 1'b0;

        firstBad = -1;
        for (int i = 0; i < obsSeq.size() && i < expSeq.size(); i++) begin
            if (obsSeq[i] != expSeq[i] && firstBad < 0) firstBad = i;
        end
        checkOutput("job_timeout", timedOut, 0);
        checkOutput("done_cycle", doneCycle, expDone);
        checkOutput("done_count", doneCount, 1);
        checkOutput("seq_length", obsSeq.size(), expSeq.size());
        checkOutput("seq_first_mismatch", firstBad, -1);
        checkOutput("idle_cycle", k, expDone + 1);
        checkOutput("pass_hold", passCnt, expPass);
    endtask

    // Starts UP to 5 and pulls reset when the counter shows 4.
    task automatic abortJob;
        int k;
        int doneSeen;
        k = 0;
        doneSeen = 0;
        applyStimulus(1'b1, 2'd0, 4'd5, 4'd0);
        stepCycle();
        start = 1'b0;
        while (!(busy && !cntClr && count == 4'd4) && k < 50) begin
            if (done) doneSeen++;
            stepCycle();
            k++;
        end
        checkOutput("abort_reached_4", (k < 50) ? 1 : 0, 1);
        checkOutput("abort_en_before", cntEn, 1);
        clear = 1'b0;
        #1;
        checkOutput("abort_en_drop", cntEn, 0);
        stepCycle();
        if (done) doneSeen++;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_cnt_en", cntEn, 0);
        checkOutput("abort_pass_cnt", passCnt, 0);
        clear = 1'b1;
        stepCycle();
        checkOutput("abort_stays_idle", busy, 0);
    endtask

    initial begin
        $display("[TB] up_down_count_sequencer bench starting");
        clear = 1'b0;
        pause = 1'b0;
        applyStimulus(1'b1, 2'd0, 4'd5, 4'd2);

        // Reset held for two edges with START high.
        for (int r = 0; r < 2; r++) begin
            stepCycle();
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_cnt_clr", cntClr, 0);
            checkOutput("rst_cnt_en", cntEn, 0);
            checkOutput("rst_cnt_up", cntUp, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_pass_cnt", passCnt, 0);
            checkOutput("rst_error", error, 0);
        end
        clear = 1'b1;
        start = 1'b0;
        stepCycle();

        // Reserved mode is ignored.
        applyStimulus(1'b1, 2'd3, 4'd5, 4'd1);
        stepCycle();
        start = 1'b0;
        checkOutput("rsvd_busy", busy, 0);
        checkOutput("rsvd_cnt_clr", cntClr, 0);
        stepCycle();
        checkOutput("rsvd_still_idle", busy, 0);

        // Directed jobs.
        runJob(0, 5, 0, -1, 0, -1);
        runJob(1, 12, 0, -1, 0, 2);
        runJob(2, 3, 2, -1, 0, 5);
        runJob(2, 3, 0, -1, 0, -1);
        runJob(0, 0, 0, -1, 0, -1);
        runJob(1, 0, 0, -1, 0, -1);
        runJob(2, 0, 1, -1, 0, -1);
        runJob(0, 5, 0, 2, 3, -1);
        abortJob();

        // Randomized jobs.
        for (int n = 0; n < 12; n++) begin
            runJob($urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 3),
                   -1, 0, ($urandom_range(0, 1) == 1) ? 3 : -1);
        end

`ifdef COUNT_WDOG_EN
        begin
            int doneSeen;
            doneSeen = 0;
            freezeCounter = 1'b1;
            stepCycle();
            applyStimulus(1'b1, 2'd0, 4'd5, 4'd0);
            stepCycle();
            start = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                stepCycle();
                if (done) doneSeen++;
                checkOutput("wdog_no_error_yet", error, 0);
            end
            stepCycle();
            if (done) doneSeen++;
            checkOutput("wdog_error", error, 1);
            checkOutput("wdog_busy", busy, 1);
            checkOutput("wdog_cnt_en", cntEn, 0);
            checkOutput("wdog_cnt_clr", cntClr, 0);
            for (int k = 0; k < 3; k++) begin
                stepCycle();
                if (done) doneSeen++;
                checkOutput("wdog_sticky", error, 1);
            end
            checkOutput("wdog_no_done", doneSeen, 0);
            clear = 1'b0;
            stepCycle();
            checkOutput("wdog_rst_error", error, 0);
            checkOutput("wdog_rst_busy", busy, 0);
            clear = 1'b1;
            freezeCounter = 1'b0;
            stepCycle();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/up_down_count_sequencer.md
Name: up_down_count_sequencer

Overview:
Controller that sequences an external mod-2^WIDTH up/down counter. It drives the counter's clear, enable and direction controls, and watches the counter's output to run one of three programmed count jobs: count up to a target, count down to a target, or bounce between 0 and a target for N passes. It sits between the host control logic and the counter datapath, and reports BUSY and DONE status.

Parameters:
WIDTH, 4, counter width; TARGET and COUNT_IN widths
TIMEOUT, 8, stall-detect limit in cycles; used only with COUNT_WDOG_EN

Ports:
CLOCK  input  1  single system clock; all state updates on the rising edge
CLEAR  input  1  synchronous active-low reset; 0 at a rising edge resets the block
START  input  1  job request; sampled only in IDLE
MODE  input  2  job type: 00 UP, 01 DOWN, 10 BOUNCE, 11 reserved
TARGET  input  WIDTH  end value for UP/DOWN; turn-around value for BOUNCE
PASSES  input  4  BOUNCE pass count; 0 is treated as 1
PAUSE  input  1  holds count progress while high
COUNT_IN  input  WIDTH  counter output; synchronous to CLOCK
CNT_CLR  output  1  active-high clear request to the counter
CNT_EN  output  1  counter enable; combinational (Mealy)
CNT_UP  output  1  direction: 1 up, 0 down
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse when a job completes
PASS_CNT  output  4  completed BOUNCE down-legs
ERROR  output  1  sticky stall flag; tied 0 without COUNT_WDOG_EN

Behaviour:
- States: IDLE, CLR, RUN_UP, RUN_DN, FINISH, plus ERR when COUNT_WDOG_EN is defined.
- Reset (CLEAR=0 at an edge): state goes to IDLE. All outputs are 0, PASS_CNT=0, latched job registers are 0. Reset has priority over every other input.
- Reset mid-job: the next edge returns the block to IDLE. No DONE pulse is issued, and CNT_EN drops immediately.
- IDLE:
  - START=1 with MODE!=11: latch MODE, TARGET and max(PASSES,1); clear PASS_CNT; go to CLR.
  - START=1 with MODE=11: ignored; the block stays in IDLE.
- CLR: lasts exactly one cycle. CNT_CLR=1, CNT_EN=0. PAUSE is ignored in this state. Next state is RUN_DN for DOWN, otherwise RUN_UP.
- RUN_UP:
  - Outputs: CNT_UP=1; CNT_EN = !PAUSE && (COUNT_IN != end value). The end value is the latched TARGET.
  - When COUNT_IN equals the end value: UP goes to FINISH; BOUNCE goes to RUN_DN.
- RUN_DN:
  - Outputs: CNT_UP=0; CNT_EN = !PAUSE && (COUNT_IN != end value). The end value is TARGET for DOWN and 0 for BOUNCE.
  - When COUNT_IN equals the end value: DOWN goes to FINISH.
  - In BOUNCE, PASS_CNT increments at the same point. If the new PASS_CNT equals the latched passes, go to FINISH; otherwise go to RUN_UP.
- FINISH: DONE=1 for one cycle, then IDLE. PASS_CNT holds its value until the next accepted START.
- DOWN starts from 0 and wraps 0 -> 2^WIDTH-1 on the way to TARGET.
- TARGET=0 edge cases:
  - UP/DOWN: zero count steps.
  - BOUNCE: each leg completes immediately, one state per leg.
- START while BUSY is ignored. Latched job fields are not affected by input changes during a job.
- Timing for UP, TARGET=T, START sampled at edge E:
  - CLR occupies cycle E..E+1; the counter clears at E+1.
  - COUNT_IN reaches T at E+1+T.
  - DONE is high in cycle E+2+T..E+3+T, and BUSY falls at E+3+T.
- CNT_CLR and CNT_EN are never high in the same cycle. CNT_EN is 0 in IDLE, CLR and FINISH.

Optional Feature:
COUNT_WDOG_EN
- Defined: a stall timer counts consecutive cycles with CNT_EN=1 and COUNT_IN unchanged from the previous cycle.
  - The timer clears on any COUNT_IN change, on CNT_EN=0, and on entry to RUN_UP/RUN_DN.
  - When the timer reaches TIMEOUT, the block enters ERR: ERROR=1, BUSY=1, CNT_EN=0, CNT_CLR=0, no DONE.
  - ERR exits only via reset.
- Undefined: no timer logic, no ERR state, ERROR is constant 0, and TIMEOUT is unused.

Test Plan:
(bench uses a behavioural synchronous up/down counter: clears on CNT_CLR, steps on CNT_EN, direction from CNT_UP)
- Reset: hold CLEAR=0 for 2 edges with START=1 -> all outputs 0, BUSY=0, no CNT_CLR pulse. MODE=11 START after reset -> stays IDLE.
- UP, TARGET=5: START at edge E -> CNT_CLR pulse in cycle E, COUNT_IN 0..5, DONE high at cycle E+7, BUSY=0 after E+8.
- DOWN, TARGET=12: counter sequence 0,15,14,13,12 (4 enabled edges), CNT_UP=0, then DONE. START pulsed mid-job is ignored.
- BOUNCE, TARGET=3, PASSES=2: sequence 0,1,2,3,2,1,0,1,2,3,2,1,0 -> PASS_CNT goes 1 then 2, DONE once. PASSES=0 -> exactly one pass.
- PAUSE high for 3 cycles at COUNT_IN=2 in UP TARGET=5 -> CNT_EN=0, count holds at 2, DONE arrives 3 cycles later. CLEAR=0 at COUNT_IN=4 -> IDLE next edge, no DONE.
- COUNT_WDOG_EN, TIMEOUT=8: bench counter frozen at 1 in UP TARGET=5 -> ERROR=1 after 8 stalled cycles, CNT_EN=0, no DONE; reset clears ERROR.
